// File: rtl/ode_step_accumulator.sv
// ode_step_accumulator
//   Sequential accumulation stage for one ODE solver step. A start pulse
//   loads y_n and a term count. Each accepted signed term is then added to
//   or subtracted from the accumulator. The result y_{n+1} and a sticky
//   overflow flag are presented through a valid/ready handshake.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start               begin a step (honoured only in IDLE)
//   init_value          y_n, sampled with start
//   num_terms           number of terms, sampled with start (0 allowed)
//   in_valid/in_ready   term handshake; in_ready depends on state only
//   in_data, in_sub     signed term; in_sub=1 subtracts it
//   out_valid/out_ready result handshake
//   out_data            accumulator value (meaningful when out_valid=1)
//   out_overflow        sticky signed-range overflow for this step
//   busy                high in ACCUM and DONE
//
// Build option:
//   ODE_ACC_SATURATE_EN  defined: clamp each out-of-range result to the
//                        signed limits. Undefined: two's-complement wrap.

module ode_step_accumulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  init_value,
  input  logic [COUNT_WIDTH-1:0] num_terms,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_overflow,
  output logic                   busy
);

  // state | meaning
  // IDLE  | waiting for start
  // ACCUM | accepting terms, one per cycle
  // DONE  | result held until out_ready
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   overflow_q, overflow_d;

  logic [DATA_WIDTH:0]    sum;
  logic                   ovf_now;
  logic [DATA_WIDTH-1:0]  next_acc;

  // One extra bit holds any sum or difference of two DATA_WIDTH signed
  // values exactly, so subtracting the most-negative value needs no special case.
  always_comb begin
    if (in_sub) sum = {acc_q[DATA_WIDTH-1], acc_q} - {in_data[DATA_WIDTH-1], in_data};
    else        sum = {acc_q[DATA_WIDTH-1], acc_q} + {in_data[DATA_WIDTH-1], in_data};
  end

  // The result is out of range when the top two bits of the exact sum differ.
  assign ovf_now = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];

`ifdef ODE_ACC_SATURATE_EN
  // The sign of the exact sum selects the limit.
  always_comb begin
    if (!ovf_now)            next_acc = sum[DATA_WIDTH-1:0];
    else if (sum[DATA_WIDTH]) next_acc = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                     next_acc = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    next_acc = sum[DATA_WIDTH-1:0];
  end
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d       = init_value;
          remaining_d = num_terms;
          overflow_d  = 1'b0;
          state_d     = (num_terms == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone means accept.
        if (in_valid) begin
          acc_d       = next_acc;
          remaining_d = remaining_q - 1'b1;
          overflow_d  = overflow_q | ovf_now;
          if (remaining_q == COUNT_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign out_data     = acc_q;
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_ode_step_accumulator.sv
module tb_ode_step_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] init_value = '0;
  logic [7:0]  num_terms = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_overflow;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [16:0] exp_q[$];

  ode_step_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .init_value(init_value),
    .num_terms(num_terms), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_overflow(out_overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops an expected {overflow, data} pair on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got data 0x%0h with no expected entry", out_data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("sb_data", {16'h0, out_data}, {16'h0, e[15:0]});
        check("sb_ovf", {31'h0, out_overflow}, {31'h0, e[16]});
      end
    end
  end

  task automatic do_start(input logic [15:0] iv, input logic [7:0] nt);
    @(posedge clk); #1;
    init_value = iv; num_terms = nt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic s);
    int n;
    n = 0;
    in_data = d; in_sub = s; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle", {31'h0, busy}, 32'h0);
  endtask

`ifdef ODE_ACC_SATURATE_EN
  localparam logic [15:0] OV1_MID = 16'h7FFF;
  localparam logic [15:0] OV1_END = 16'h7FDF;
  localparam logic [15:0] NEG_RES = 16'h7FFF;
  localparam logic [15:0] BP_RES  = 16'h7FFF;
`else
  localparam logic [15:0] OV1_MID = 16'h8010;
  localparam logic [15:0] OV1_END = 16'h7FF0;
  localparam logic [15:0] NEG_RES = 16'h8000;
  localparam logic [15:0] BP_RES  = 16'h8000;
`endif

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_ovf", {31'h0, out_overflow}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Gapped terms: 0x10 + 5 - 3 + 0x100 = 0x112
    exp_q.push_back({1'b0, 16'h0112});
    do_start(16'h0010, 8'd3);
    check("accum_in_ready", {31'h0, in_ready}, 32'h1);
    check("accum_busy", {31'h0, busy}, 32'h1);
    send(16'h0005, 1'b0);
    idle(2);
    send(16'h0003, 1'b1);
    idle(1);
    check("gap_out_valid", {31'h0, out_valid}, 32'h0);
    send(16'h0100, 1'b0);
    check("latency_out_valid", {31'h0, out_valid}, 32'h1);
    check("done_in_ready", {31'h0, in_ready}, 32'h0);
    wait_idle();

    // Zero terms; start while in DONE is ignored
    out_ready = 1'b0;
    do_start(16'h1234, 8'd0);
    check("zero_out_valid", {31'h0, out_valid}, 32'h1);
    init_value = 16'h5555; num_terms = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_start_valid", {31'h0, out_valid}, 32'h1);
    check("ign_start_data", {16'h0, out_data}, 32'h1234);
    exp_q.push_back({1'b0, 16'h1234});
    out_ready = 1'b1;
    wait_idle();

    // Overflow then back into range
    exp_q.push_back({1'b1, OV1_END});
    do_start(16'h7FF0, 8'd2);
    send(16'h0020, 1'b0);
    check("ovf_mid_data", {16'h0, out_data}, {16'h0, OV1_MID});
    send(16'h0020, 1'b1);
    wait_idle();

    // 0 - 0x8000 is exactly +32768
    exp_q.push_back({1'b1, NEG_RES});
    do_start(16'h0000, 8'd1);
    send(16'h8000, 1'b1);
    wait_idle();

    // Backpressure: 0x0100 + 0x7F00 = +32768
    out_ready = 1'b0;
    do_start(16'h0100, 8'd1);
    send(16'h7F00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, out_valid}, 32'h1);
      check("bp_data", {16'h0, out_data}, {16'h0, BP_RES});
      check("bp_ovf", {31'h0, out_overflow}, 32'h1);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    exp_q.push_back({1'b1, BP_RES});
    out_ready = 1'b1;
    wait_idle();
    exp_q.push_back({1'b0, 16'h0002});
    do_start(16'h0001, 8'd1);
    check("clear_ovf", {31'h0, out_overflow}, 32'h0);
    send(16'h0001, 1'b0);
    wait_idle();

    // Reset after 2 of 4 terms abandons the step
    do_start(16'h0003, 8'd4);
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_data", {16'h0, out_data}, 32'h0);
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({1'b0, 16'h0006});
    do_start(16'h0005, 8'd1);
    send(16'h0001, 1'b0);
    wait_idle();

    idle(3);
    check("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ode_step_accumulator.md
Name: ode_step_accumulator

Overview:
- Sequential accumulation stage directly downstream of the 16-bit signed adder/subtractor datapath in the ODE solver.
- Loads an initial state value y_n, then consumes a programmed number of signed increment terms (h·f products), each added or subtracted per term.
- Emits y_{n+1} with a sticky overflow flag through a valid/ready output handshake.
- Feeds the solver's state register file.

Parameters:
- DATA_WIDTH, 16: width of the state value and of each term, signed two's complement; must be a multiple of 4.
- COUNT_WIDTH, 8: width of the term counter; at most 2^COUNT_WIDTH-1 terms per step.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begin a step; honoured only in IDLE
- init_value  in  DATA_WIDTH  signed y_n, sampled with start
- num_terms  in  COUNT_WIDTH  number of terms to accumulate, sampled with start
- in_valid  in  1  term available
- in_ready  out  1  block accepts a term this cycle
- in_data  in  DATA_WIDTH  signed term
- in_sub  in  1  1 = subtract term, 0 = add; qualified by in_valid
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_WIDTH  signed accumulated result
- out_overflow  out  1  sticky: some operation in this step exceeded signed range
- busy  out  1  high in ACCUM and DONE

Behaviour:
- Reset (async, immediate): state=IDLE; acc=0; remaining=0; in_ready=0; out_valid=0; out_data=0; out_overflow=0; busy=0. Reset mid-step abandons the step; no output is produced.
- FSM states:
  - IDLE: in_ready=0, out_valid=0. On start: acc<=init_value, remaining<=num_terms, overflow<=0. If num_terms==0, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready=1. A term is accepted on in_valid&&in_ready: acc<=next_acc, remaining<=remaining-1, overflow<=overflow|ovf_now. When remaining==1 and a term is accepted, go to DONE. When in_valid=0, hold all state.
  - DONE: in_ready=0, out_valid=1. out_data and out_overflow stay stable until out_ready. On out_valid&&out_ready, go to IDLE in the next cycle.
- in_ready is a registered function of state only; it never depends combinationally on in_valid.
- Arithmetic, computed exactly in DATA_WIDTH+1 bits:
  - sum = sext(acc) + sext(in_data) when in_sub=0.
  - sum = sext(acc) − sext(in_data) when in_sub=1.
  - ovf_now = 1 when sum lies outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Subtracting the most-negative value is handled exactly; there is no negate-overflow corner.
- Latency:
  - One accepted term per cycle.
  - out_valid asserts in the cycle after the last term is accepted.
  - For num_terms=0, out_valid asserts in the cycle after start.
- start in ACCUM or DONE is ignored; it has no effect on state or registers.
- out_data = acc and out_overflow = overflow at all times; they are meaningful only when out_valid=1.
- Back-to-back steps: the earliest next start is the cycle the FSM is back in IDLE, one cycle after the output handshake.

Optional Feature:
- Macro: ODE_ACC_SATURATE_EN.
- Defined: on ovf_now, next_acc clamps to +2^(DATA_WIDTH−1)−1 (0x7FFF) for a positive out-of-range sum, or −2^(DATA_WIDTH−1) (0x8000) for a negative one. Clamping is applied per term; later terms operate on the clamped value.
- Undefined: next_acc = sum[DATA_WIDTH−1:0] (two's-complement wrap).
- out_overflow is set identically in both builds.

Test Plan:
- Reset during ACCUM, after 2 of 4 terms: outputs return to reset values immediately; a later start with init 0x0005 and 1 term +0x0001 gives out_data=0x0006.
- start, init=0x0010, num_terms=3; terms +0x0005, −0x0003 (in_sub=1), +0x0100; in_valid gapped by idle cycles → out_data=0x0112, out_overflow=0; out_valid one cycle after the 3rd accept.
- num_terms=0, init=0x1234 → out_valid the next cycle, out_data=0x1234, out_overflow=0; a start pulse while in DONE is ignored.
- init=0x7FF0, 2 terms +0x0020 then −0x0020:
  - With ODE_ACC_SATURATE_EN: results 0x7FFF, then 0x7FDF, overflow=1.
  - Without: 0x8010, then 0x7FF0, overflow=1.
- init=0x0000, 1 term subtract 0x8000: exact sum +32768 → overflow=1; out_data=0x7FFF (saturate build) or 0x8000 (wrap build).
- Output backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, out_data and out_overflow stay stable and in_ready=0; releasing out_ready returns to IDLE, and the next step clears out_overflow.
